fetch_stage_ctrl: RTL and testbench

//   Front-end consumer of the load-use hazard signals: owns the PC register and the
//   IF/ID pipeline register of the 5-stage RV32I pipe. Honours pc_write/ifid_write

---
 rtl/fetch_if.sv | 34 +++
 rtl/fetch_stage_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect controls in, imem read port and IF/ID view out.
// master = hazard unit / pipeline side, slave = fetch_stage_ctrl.
interface fetch_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned ILEN = 32;

  logic            pc_write;
  logic            ifid_write;
  logic            bubble;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [ILEN-1:0] imem_rdata;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] ifid_ins;
  logic [XLEN-1:0] ifid_pc;
  logic            ifid_valid;
  logic            idex_bubble;
  logic [1:0]      state_o;
  logic            proto_err;
  logic [31:0]     stall_cnt;

  modport master (
    output pc_write, ifid_write, bubble, branch_taken, branch_target, imem_rdata,
    input  imem_addr, ifid_ins, ifid_pc, ifid_valid, idex_bubble, state_o, proto_err,
           stall_cnt
  );

  modport slave (
    input  pc_write, ifid_write, bubble, branch_taken, branch_target, imem_rdata,
    output imem_addr, ifid_ins, ifid_pc, ifid_valid, idex_bubble, state_o, proto_err,
           stall_cnt
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// PC and IF/ID register owner for the 5-stage RV32I pipe: stall, bubble, branch flush.
// Optional stall-cycle counter enabled by defining STALL_PERF_CNT_EN.
module fetch_stage_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [31:0]     NOP_INS  = 32'h0000_0013
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);

  localparam int unsigned ILEN  = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] ifid_ins_q, ifid_ins_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            idex_bubble_q, idex_bubble_d;
  logic            proto_err_q, proto_err_d;

  logic            advance_c;
  logic            mismatch_c;
  logic            in_flush_c;

  assign advance_c  = bus.pc_write & bus.ifid_write;
  assign mismatch_c = bus.pc_write ^ bus.ifid_write;
  assign in_flush_c = (state_q == ST_FLUSH);

  // Priority outside BOOT: branch redirect, then stall/mismatch hold, then sequential fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_ins_d    = ifid_ins_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    idex_bubble_d = idex_bubble_q;
    proto_err_d   = proto_err_q;

    case (state_q)
      ST_BOOT: begin
        state_d       = ST_RUN;
        idex_bubble_d = 1'b1;
      end
      default: begin
        if (bus.branch_taken) begin
          state_d       = ST_FLUSH;
          pc_d          = bus.branch_target;
          ifid_ins_d    = NOP_INS;
          ifid_pc_d     = '0;
          ifid_valid_d  = 1'b0;
          idex_bubble_d = 1'b1;
        end else if (advance_c) begin
          state_d       = ST_RUN;
          pc_d          = pc_q + XLEN'(PC_STEP);
          ifid_ins_d    = bus.imem_rdata;
          ifid_pc_d     = pc_q;
          ifid_valid_d  = 1'b1;
          idex_bubble_d = in_flush_c | bus.bubble;
        end else begin
          // Mismatched write enables hold both registers like a regular stall.
          state_d       = ST_STALL;
          idex_bubble_d = in_flush_c | bus.bubble;
          if (mismatch_c && !in_flush_c) begin
            proto_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      ifid_ins_q    <= NOP_INS;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      idex_bubble_q <= 1'b1;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_ins_q    <= ifid_ins_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      idex_bubble_q <= idex_bubble_d;
      proto_err_q   <= proto_err_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles ending in STALL, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_d == ST_STALL) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = CNT_W'(0);
`endif

  assign bus.imem_addr   = pc_q;
  assign bus.ifid_ins    = ifid_ins_q;
  assign bus.ifid_pc     = ifid_pc_q;
  assign bus.ifid_valid  = ifid_valid_q;
  assign bus.idex_bubble = idex_bubble_q;
  assign bus.state_o     = state_q;
  assign bus.proto_err   = proto_err_q;

  // BOOT never lasts more than one cycle.
  boot_one_cycle_a: assert property (
    @(posedge clk) disable iff (rst) (state_q == ST_BOOT) |=> (state_q == ST_RUN)
  );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Testbench for fetch_stage_ctrl: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage_ctrl;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if #(.XLEN(32)) bus ();

  fetch_stage_ctrl #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[17:2]};
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_pc, m_ins, m_ifpc, m_cnt;
  logic        m_valid, m_bub, m_err;
  logic [1:0]  m_state;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies the fetch rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic flush;
    if (rst) begin
      m_pc = 32'h0; m_ins = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
      m_bub = 1'b1; m_state = S_BOOT; m_err = 1'b0; m_cnt = 32'h0;
    end else if (m_state == S_BOOT) begin
      m_state = S_RUN;
      m_bub   = 1'b1;
    end else begin
      flush = (m_state == S_FLUSH);
      if (bus.branch_taken) begin
        m_pc = bus.branch_target; m_ins = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
        m_bub = 1'b1; m_state = S_FLUSH;
      end else if (bus.pc_write && bus.ifid_write) begin
        m_ifpc  = m_pc;
        m_ins   = imem_word(m_pc);
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_bub   = flush ? 1'b1 : bus.bubble;
        m_state = S_RUN;
      end else begin
        if ((bus.pc_write != bus.ifid_write) && !flush) m_err = 1'b1;
        m_bub   = flush ? 1'b1 : bus.bubble;
        m_state = S_STALL;
`ifdef STALL_PERF_CNT_EN
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
      end
    end
  endtask

  task automatic check_all();
    check_val("imem_addr",   bus.imem_addr,          m_pc);
    check_val("ifid_ins",    bus.ifid_ins,           m_ins);
    check_val("ifid_pc",     bus.ifid_pc,            m_ifpc);
    check_val("ifid_valid",  32'(bus.ifid_valid),    32'(m_valid));
    check_val("idex_bubble", 32'(bus.idex_bubble),   32'(m_bub));
    check_val("state_o",     32'(bus.state_o),       32'(m_state));
    check_val("proto_err",   32'(bus.proto_err),     32'(m_err));
    check_val("stall_cnt",   bus.stall_cnt,          m_cnt);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic pw, input logic iw, input logic bub,
                       input logic br, input logic [31:0] tgt);
    bus.pc_write      = pw;
    bus.ifid_write    = iw;
    bus.bubble        = bub;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    m_pc = 32'h0; m_ins = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
    m_bub = 1'b1; m_state = S_BOOT; m_err = 1'b0; m_cnt = 32'h0;

    // T1: reset, boot, sequential fetch
    cycle(); cycle();
    check_val("t1_rst_state", 32'(bus.state_o), 32'(S_BOOT));
    check_val("t1_rst_valid", 32'(bus.ifid_valid), 32'h0);
    rst = 1'b0;
    cycle();
    check_val("t1_run_addr0", bus.imem_addr, 32'h0);
    check_val("t1_run_state", 32'(bus.state_o), 32'(S_RUN));
    cycle();
    check_val("t1_addr4", bus.imem_addr, 32'h4);
    check_val("t1_ifpc0", bus.ifid_pc, 32'h0);
    cycle();
    check_val("t1_addr8", bus.imem_addr, 32'h8);
    check_val("t1_ifpc4", bus.ifid_pc, 32'h4);

    // T2: single stall with bubble
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle();
    check_val("t2_pc_hold", bus.imem_addr, 32'h8);
    check_val("t2_ifpc_hold", bus.ifid_pc, 32'h4);
    check_val("t2_bubble", 32'(bus.idex_bubble), 32'h1);
    check_val("t2_state", 32'(bus.state_o), 32'(S_STALL));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    check_val("t2_release_pc", bus.imem_addr, 32'hC);

    // T3: branch overrides stall
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    cycle();
    check_val("t3_pc", bus.imem_addr, 32'h100);
    check_val("t3_nop", bus.ifid_ins, NOP);
    check_val("t3_state", 32'(bus.state_o), 32'(S_FLUSH));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    check_val("t3_ifpc", bus.ifid_pc, 32'h100);
    check_val("t3_valid", 32'(bus.ifid_valid), 32'h1);
    check_val("t3_flush_bubble", 32'(bus.idex_bubble), 32'h1);

    // T4: mismatched enables
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check_val("t4_pc_hold", bus.imem_addr, 32'h104);
    check_val("t4_proto_err", 32'(bus.proto_err), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle();
    check_val("t4_sticky", 32'(bus.proto_err), 32'h1);

    // T5: PC wrap
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    check_val("t5_wrap", bus.imem_addr, 32'h0);

    // T6: stall counter and reset mid-stall
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle();
`ifdef STALL_PERF_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    check_val("t6_cnt", bus.stall_cnt, exp_cnt);
    rst = 1'b1;
    cycle();
    check_val("t6_rst_state", 32'(bus.state_o), 32'(S_BOOT));
    check_val("t6_rst_cnt", bus.stall_cnt, 32'h0);
    check_val("t6_rst_pc", bus.imem_addr, 32'h0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int unsigned k;
      logic [31:0] tgt;
      logic        br;
      rst = ($urandom_range(0, 199) == 0);
      br  = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
      k = $urandom_range(0, 19);
      if (k < 4)
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), br, tgt);
      else if (k == 4 && m_state != S_FLUSH) begin
        if ($urandom_range(0, 1) == 1) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), br, tgt);
        else                           drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), br, tgt);
      end else
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), br, tgt);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
